// File: rtl/unknown_protocol_pkg.sv
// Shared types and helpers for the unknown-protocol symbol link.
package unknown_protocol_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StPayload,
        StGap
    } tx_state_e;

    localparam logic [2:0]  MAGIC_DEFAULT    = 3'b101;
    localparam int unsigned IDLE_SYM_DEFAULT = 0;

    // Bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/unknown_protocol_frame_buf.sv
// One-entry pending frame buffer: written on an accept outside a launch point,
// cleared when its frame is launched.
module unknown_protocol_frame_buf
    import unknown_protocol_pkg::*;
#(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic              pending_valid,
    output logic [DATA_W-1:0] pending_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (clr) begin
                valid_q <= 1'b0;
            end
            if (wr_en) begin
                valid_q <= 1'b1;
                data_q  <= wr_data;
            end
        end
    end

    assign pending_valid = valid_q;
    assign pending_data  = data_q;

endmodule

// File: rtl/unknown_protocol_tx.sv
// Transmit end of the unknown-protocol link: serialises accepted frames as
// preamble, payload and gap symbols. The symbol bus is named seq because
// `sequence` is a reserved word in SystemVerilog.
module unknown_protocol_tx
    import unknown_protocol_pkg::*;
#(
    parameter int unsigned               COUNT_FOR_VALID = 2,
    parameter int unsigned               SEQUENCE_WIDTH  = 3,
    parameter logic [SEQUENCE_WIDTH-1:0] MAGIC           = SEQUENCE_WIDTH'(MAGIC_DEFAULT),
    parameter int unsigned               PAYLOAD_LEN     = 4,
    parameter int unsigned               GAP_CYCLES      = 1,
    parameter logic [SEQUENCE_WIDTH-1:0] IDLE_SYM        = SEQUENCE_WIDTH'(IDLE_SYM_DEFAULT)
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PAYLOAD_LEN*SEQUENCE_WIDTH-1:0] in_data,
    output logic [SEQUENCE_WIDTH-1:0]             seq,
    output logic                                  enable,
    output logic                                  busy,
    output logic                                  frame_done
);

    localparam int unsigned DATA_W  = PAYLOAD_LEN * SEQUENCE_WIDTH;
    localparam int unsigned CNT_MAX = max3(COUNT_FOR_VALID, PAYLOAD_LEN, GAP_CYCLES);
    localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE     = CNT_W'(COUNT_FOR_VALID);
    localparam logic [CNT_W-1:0] CNT_PAYLOAD = CNT_W'(PAYLOAD_LEN);
    localparam logic [CNT_W-1:0] CNT_GAP     = CNT_W'(GAP_CYCLES);

    tx_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    logic [SEQUENCE_WIDTH-1:0] seq_q, seq_d;
    logic enable_q, enable_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic              pending_valid;
    logic [DATA_W-1:0] pending_data;
    logic              buf_wr;
    logic              buf_clr;
    logic              launch_pt;
    logic              accept;

    assign in_ready  = !pending_valid;
    assign accept    = in_valid && in_ready;
    assign launch_pt = (state_q == StIdle) || ((state_q == StGap) && (cnt_q == CNT_ONE));

    unknown_protocol_frame_buf #(
        .DATA_W(DATA_W)
    ) u_frame_buf (
        .clk          (clk),
        .resetn       (resetn),
        .wr_en        (buf_wr),
        .wr_data      (in_data),
        .clr          (buf_clr),
        .pending_valid(pending_valid),
        .pending_data (pending_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        buf_wr  = 1'b0;
        buf_clr = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StPreamble: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = StPayload;
                    cnt_d   = CNT_PAYLOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StPayload: begin
                shreg_d = shreg_q >> SEQUENCE_WIDTH;
                if (cnt_q == CNT_ONE) begin
                    state_d = StGap;
                    cnt_d   = CNT_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StGap: begin
                if (cnt_q != CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        endcase

        // A pending frame always has priority; otherwise an offered frame
        // bypasses the buffer so an idle link starts one edge after accept.
        if (launch_pt) begin
            if (pending_valid) begin
                state_d = StPreamble;
                cnt_d   = CNT_PRE;
                shreg_d = pending_data;
                buf_clr = 1'b1;
            end else if (in_valid) begin
                state_d = StPreamble;
                cnt_d   = CNT_PRE;
                shreg_d = in_data;
            end else begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end else begin
            buf_wr = accept;
        end
    end

    always_comb begin
        seq_d    = IDLE_SYM;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StPreamble: begin
                seq_d    = MAGIC;
                enable_d = 1'b1;
                busy_d   = 1'b1;
            end
            StPayload: begin
                seq_d    = shreg_q[SEQUENCE_WIDTH-1:0];
                enable_d = 1'b1;
                busy_d   = 1'b1;
                done_d   = (cnt_q == CNT_ONE);
            end
            StGap: begin
                enable_d = 1'b1;
                busy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shreg_q  <= '0;
            seq_q    <= IDLE_SYM;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            seq_q    <= seq_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign seq        = seq_q;
    assign enable     = enable_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
